// File: rtl/hard_muxn_seq.sv
// N-channel hard mux with break-before-make channel switching (GAP idle cycles).
// Optional out-of-range select rejection: define HARD_MUXN_SEQ_SEL_CHECK_EN.
module hard_muxn_seq #(
  parameter int NB_CH   = 4,
  parameter int WIDTH   = 1,
  parameter int GAP     = 2,
  parameter int RST_SEL = 0,
  parameter logic [WIDTH-1:0] IDLE_VAL = '0,
  localparam int SEL_W  = $clog2(NB_CH)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [NB_CH*WIDTH-1:0] i_in,
  input  logic                   i_sel_req,
  input  logic [SEL_W-1:0]       i_sel,
  output logic [WIDTH-1:0]       o_z,
  output logic                   o_en,
  output logic [SEL_W-1:0]       o_sel_cur,
  output logic                   o_busy,
  output logic                   o_sel_ack,
  output logic                   o_sel_err
);

  localparam int CNT_W = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(GAP - 1);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_BREAK = 1'b1} state_t;

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [SEL_W-1:0] pend_r, pend_s;
  logic [SEL_W-1:0] sel_cur_r, sel_cur_s;
  logic             en_r, en_s;
  logic             busy_r, busy_s;
  logic             ack_r, ack_s;
  logic             brk_ack_r, brk_ack_s;
  logic             err_r, err_s;
  logic             sel_oor_s;

  // Channel selector; a select with no matching channel yields IDLE_VAL.
  function automatic logic [WIDTH-1:0] pick(input logic [NB_CH*WIDTH-1:0] din,
                                            input logic [SEL_W-1:0] sel);
    logic [WIDTH-1:0] r;
    r = IDLE_VAL;
    for (int k = 0; k < NB_CH; k++) begin
      r = (sel == SEL_W'(k)) ? din[k*WIDTH +: WIDTH] : r;
    end
    return r;
  endfunction

`ifdef HARD_MUXN_SEQ_SEL_CHECK_EN
  // True when sel names an existing channel; never false for power-of-2 NB_CH.
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    logic v;
    v = 1'b0;
    for (int k = 0; k < NB_CH; k++) begin
      v = v | (sel == SEL_W'(k));
    end
    return v;
  endfunction

  assign sel_oor_s = ~sel_valid(i_sel);
`else
  assign sel_oor_s = 1'b0;
`endif

  // Next-state and next-output logic for the switch sequencer.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    pend_s    = pend_r;
    sel_cur_s = sel_cur_r;
    en_s      = en_r;
    busy_s    = busy_r;
    ack_s     = 1'b0;
    brk_ack_s = 1'b0;
    err_s     = 1'b0;
    case (state_r)
      ST_RUN: begin
        en_s   = 1'b1;
        busy_s = 1'b0;
        // The ack cycle that closes a break still refuses new requests.
        if (i_sel_req && !brk_ack_r) begin
          if (sel_oor_s) begin
            err_s = 1'b1;
          end else if (i_sel != sel_cur_r) begin
            state_s = ST_BREAK;
            pend_s  = i_sel;
            cnt_s   = CNT_INIT;
            en_s    = 1'b0;
            busy_s  = 1'b1;
          end else begin
            ack_s = 1'b1;
          end
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_BREAK: begin
        if (cnt_r != {CNT_W{1'b0}}) begin
          cnt_s = cnt_r - CNT_W'(1);
        end else begin
          state_s   = ST_RUN;
          sel_cur_s = pend_r;
          en_s      = 1'b1;
          busy_s    = 1'b0;
          ack_s     = 1'b1;
          brk_ack_s = 1'b1;
        end
      end
      default: begin
        state_s   = ST_RUN;
        cnt_s     = {CNT_W{1'b0}};
        sel_cur_s = SEL_W'(RST_SEL);
        en_s      = 1'b1;
        busy_s    = 1'b0;
      end
    endcase
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r   <= ST_RUN;
      cnt_r     <= {CNT_W{1'b0}};
      pend_r    <= SEL_W'(RST_SEL);
      sel_cur_r <= SEL_W'(RST_SEL);
      en_r      <= 1'b1;
      busy_r    <= 1'b0;
      ack_r     <= 1'b0;
      brk_ack_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      pend_r    <= pend_s;
      sel_cur_r <= sel_cur_s;
      en_r      <= en_s;
      busy_r    <= busy_s;
      ack_r     <= ack_s;
      brk_ack_r <= brk_ack_s;
      err_r     <= err_s;
    end
  end

  // Data path stays combinational so selected data reaches o_z with no latency.
  always_comb begin
    if (en_r) begin
      o_z = pick(i_in, sel_cur_r);
    end else begin
      o_z = IDLE_VAL;
    end
  end

  assign o_en      = en_r;
  assign o_sel_cur = sel_cur_r;
  assign o_busy    = busy_r;
  assign o_sel_ack = ack_r;
  assign o_sel_err = err_r;

endmodule

// File: tb/tb_hard_muxn_seq.sv
// Self-checking bench for hard_muxn_seq: table of per-cycle vectors through a
// scoreboard queue, plus hand sequences for data passthrough and NB_CH=3 range handling.
module tb_hard_muxn_seq;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic        req;
  logic [1:0]  sel;
  logic [7:0]  z;
  logic        en;
  logic [1:0]  cur;
  logic        busy;
  logic        ack;
  logic        err;

  logic        rst3;
  logic [23:0] din3;
  logic        req3;
  logic [1:0]  sel3;
  logic [7:0]  z3;
  logic        en3;
  logic [1:0]  cur3;
  logic        busy3;
  logic        ack3;
  logic        err3;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rst;
    logic       req;
    logic [1:0] sel;
    logic [7:0] z;
    logic       en;
    logic [1:0] cur;
    logic       busy;
    logic       ack;
  } vec_t;

  typedef struct packed {
    logic [7:0] z;
    logic       en;
    logic [1:0] cur;
    logic       busy;
    logic       ack;
    logic       err;
  } obs_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];
  obs_t sb_q [$];

  hard_muxn_seq #(.NB_CH(4), .WIDTH(8), .GAP(2), .RST_SEL(0), .IDLE_VAL(8'h00)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_in(din), .i_sel_req(req), .i_sel(sel),
    .o_z(z), .o_en(en), .o_sel_cur(cur), .o_busy(busy), .o_sel_ack(ack), .o_sel_err(err)
  );

  hard_muxn_seq #(.NB_CH(3), .WIDTH(8), .GAP(2), .RST_SEL(0), .IDLE_VAL(8'h00)) u_dut3 (
    .i_clk(clk), .i_rst(rst3), .i_in(din3), .i_sel_req(req3), .i_sel(sel3),
    .o_z(z3), .o_en(en3), .o_sel_cur(cur3), .o_busy(busy3), .o_sel_ack(ack3), .o_sel_err(err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic q, input logic [1:0] s,
                              input logic [7:0] ez, input logic ee, input logic [1:0] ec,
                              input logic eb, input logic ea);
    vec_t v;
    v.rst = r; v.req = q; v.sel = s;
    v.z = ez; v.en = ee; v.cur = ec; v.busy = eb; v.ack = ea;
    return v;
  endfunction

  task automatic check_obs(input string name, input obs_t got, input obs_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got z=%h en=%b cur=%0d busy=%b ack=%b err=%b, want z=%h en=%b cur=%0d busy=%b ack=%b err=%b",
               name, got.z, got.en, got.cur, got.busy, got.ack, got.err,
               exp.z, exp.en, exp.cur, exp.busy, exp.ack, exp.err);
    end
  endtask

  function automatic obs_t obs4();
    obs_t o;
    o.z = z; o.en = en; o.cur = cur; o.busy = busy; o.ack = ack; o.err = err;
    return o;
  endfunction

  function automatic obs_t obs3();
    obs_t o;
    o.z = z3; o.en = en3; o.cur = cur3; o.busy = busy3; o.ack = ack3; o.err = err3;
    return o;
  endfunction

  function automatic obs_t mko(input logic [7:0] ez, input logic ee, input logic [1:0] ec,
                               input logic eb, input logic ea, input logic er);
    obs_t o;
    o.z = ez; o.en = ee; o.cur = ec; o.busy = eb; o.ack = ea; o.err = er;
    return o;
  endfunction

  task automatic step3(input logic r, input logic q, input logic [1:0] s,
                       input string name, input obs_t exp);
    rst3 = r; req3 = q; sel3 = s;
    @(posedge clk); #1;
    check_obs(name, obs3(), exp);
  endtask

  initial begin
    obs_t exp;
    obs_t e3_err;
    string nm;

    // Rows: stimulus for one cycle, expected outputs after the edge that samples it.
    tbl[0]  = mk(1'b1, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[1]  = mk(1'b1, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[2]  = mk(1'b0, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[3]  = mk(1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[4]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[5]  = mk(1'b0, 1'b0, 2'd0, 8'hA2, 1'b1, 2'd2, 1'b0, 1'b1);
    tbl[6]  = mk(1'b0, 1'b0, 2'd0, 8'hA2, 1'b1, 2'd2, 1'b0, 1'b0);
    tbl[7]  = mk(1'b0, 1'b1, 2'd0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b1);
    tbl[10] = mk(1'b0, 1'b1, 2'd3, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[11] = mk(1'b0, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[12] = mk(1'b0, 1'b1, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b1);
    tbl[13] = mk(1'b0, 1'b1, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b1);
    tbl[14] = mk(1'b0, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[15] = mk(1'b0, 1'b1, 2'd1, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[16] = mk(1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[17] = mk(1'b0, 1'b1, 2'd3, 8'hA1, 1'b1, 2'd1, 1'b0, 1'b1);
    tbl[18] = mk(1'b0, 1'b1, 2'd3, 8'hA1, 1'b1, 2'd1, 1'b0, 1'b0);
    tbl[19] = mk(1'b0, 1'b0, 2'd0, 8'hA1, 1'b1, 2'd1, 1'b0, 1'b0);
    tbl[20] = mk(1'b0, 1'b1, 2'd3, 8'h00, 1'b0, 2'd1, 1'b1, 1'b0);
    tbl[21] = mk(1'b1, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[22] = mk(1'b0, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[23] = mk(1'b0, 1'b0, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b0);
    tbl[24] = mk(1'b0, 1'b1, 2'd0, 8'hA0, 1'b1, 2'd0, 1'b0, 1'b1);
    tbl[25] = mk(1'b0, 1'b1, 2'd2, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[26] = mk(1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 1'b1, 1'b0);
    tbl[27] = mk(1'b0, 1'b0, 2'd0, 8'hA2, 1'b1, 2'd2, 1'b0, 1'b1);
    tbl[28] = mk(1'b0, 1'b0, 2'd0, 8'hA2, 1'b1, 2'd2, 1'b0, 1'b0);

    din  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    din3 = {8'hA2, 8'hA1, 8'hA0};
    rst = 1'b1; req = 1'b0; sel = 2'd0;
    rst3 = 1'b1; req3 = 1'b0; sel3 = 2'd0;
    @(posedge clk); #1;

    for (int i = 0; i < NVEC; i++) begin
      rst = tbl[i].rst; req = tbl[i].req; sel = tbl[i].sel;
      sb_q.push_back(mko(tbl[i].z, tbl[i].en, tbl[i].cur, tbl[i].busy, tbl[i].ack, 1'b0));
      @(posedge clk); #1;
      exp = sb_q.pop_front();
      nm = $sformatf("vec%0d", i);
      check_obs(nm, obs4(), exp);
    end
    req = 1'b0;

    // Data path is combinational: a change on the connected channel shows at once.
    din[23:16] = 8'h5A;
    #1;
    check_obs("data_pass", obs4(), mko(8'h5A, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0));
    din[31:24] = 8'hC3;
    #1;
    check_obs("data_other", obs4(), mko(8'h5A, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0));

    // Three-channel instance: request for the non-existent channel 3.
    step3(1'b1, 1'b0, 2'd0, "n3_rst", mko(8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
`ifdef HARD_MUXN_SEQ_SEL_CHECK_EN
    e3_err = mko(8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1);
    step3(1'b0, 1'b1, 2'd3, "n3_err", e3_err);
    step3(1'b0, 1'b0, 2'd0, "n3_err_end", mko(8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
    step3(1'b0, 1'b0, 2'd0, "n3_idle", mko(8'hA0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0));
`else
    e3_err = mko(8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
    step3(1'b0, 1'b1, 2'd3, "n3_brk1", e3_err);
    step3(1'b0, 1'b0, 2'd0, "n3_brk2", mko(8'h00, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0));
    step3(1'b0, 1'b0, 2'd0, "n3_ack", mko(8'h00, 1'b1, 2'd3, 1'b0, 1'b1, 1'b0));
    step3(1'b0, 1'b0, 2'd0, "n3_conn", mko(8'h00, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0));
`endif
    step3(1'b0, 1'b1, 2'd1, "n3_sw1", mko(8'h00, 1'b0, cur3, 1'b1, 1'b0, 1'b0));
    step3(1'b0, 1'b0, 2'd0, "n3_sw1b", mko(8'h00, 1'b0, cur3, 1'b1, 1'b0, 1'b0));
    step3(1'b0, 1'b0, 2'd0, "n3_sw1ack", mko(8'hA1, 1'b1, 2'd1, 1'b0, 1'b1, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
